// File: rtl/alu_pkg.sv
// alu_pkg: ALUctl encodings shared by the alu and everything that feeds it.
package alu_pkg;
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    function automatic logic alu_ctl_legal(input logic [3:0] ctl);
        return ctl inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
    endfunction
endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: requester bundle plus registered result channel of the shared alu.
interface alu_share_arb_if #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] ctl;
    logic [W*NREQ-1:0] a_in;
    logic [W*NREQ-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic              out_valid;
    logic              out_ready;
    logic [IDW-1:0]    out_id;
    logic [W-1:0]      out_result;
    logic              out_zero;
    logic              out_err;

    modport master (
        output req, ctl, a_in, b_in, out_ready,
        input  gnt, out_valid, out_id, out_result, out_zero, out_err
    );
    modport slave (
        input  req, ctl, a_in, b_in, out_ready,
        output gnt, out_valid, out_id, out_result, out_zero, out_err
    );
endinterface

// File: rtl/alu.sv
// alu: combinational MIPS-style ALU; unsupported ALUctl codes yield zero.
module alu
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [3:0]   ALUctl,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] ALUOut,
    output logic         Zero
);
    always_comb begin
        ALUOut = ALUctl == ALU_AND ? A & B :
                 ALUctl == ALU_OR  ? A | B :
                 ALUctl == ALU_ADD ? A + B :
                 ALUctl == ALU_SUB ? A - B :
                 ALUctl == ALU_SLT ? {{(W-1){1'b0}}, $signed(A) < $signed(B)} :
                 ALUctl == ALU_NOR ? ~(A | B) : '0;
        Zero = ALUOut == '0;
    end
endmodule

// File: rtl/rr_pick.sv
// rr_pick: round-robin priority pick; search starts at ptr and wraps modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);
    logic [2*NREQ-1:0] dbl;
    logic [IDW-1:0]    off;
    logic [IDW:0]      sum;
    logic              hit;

    // idx never depends on en, so the operand mux stays off the out_ready path
    always_comb begin
        dbl = {req, req} >> ptr;
        off = '0;
        hit = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!hit && dbl[k]) begin
                hit = 1'b1;
                off = IDW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        idx = IDW'(sum >= (IDW+1)'(NREQ) ? sum - (IDW+1)'(NREQ) : sum);
        gnt = (en && hit) ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one alu among NREQ requesters round-robin, with a
// single-entry registered result slot under valid/ready backpressure.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = $clog2(NREQ)
) (
    input logic            clk,
    input logic            rst_n,
    alu_share_arb_if.slave bus
);
    logic            free;
    logic            legal;
    logic            alu_zero;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  idx;
    logic [3:0]      sel_ctl;
    logic [W-1:0]    sel_a, sel_b, alu_out;
    logic            valid_q, valid_d, zero_q, zero_d, err_q, err_d;
    logic [IDW-1:0]  id_q, id_d, ptr_q, ptr_d;
    logic [W-1:0]    result_q, result_d;

    assign free = !valid_q || bus.out_ready;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .en  (free && rst_n),
        .gnt (gnt),
        .idx (idx)
    );

    assign sel_ctl = bus.ctl[int'(idx)*4 +: 4];
    assign sel_a   = bus.a_in[int'(idx)*W +: W];
    assign sel_b   = bus.b_in[int'(idx)*W +: W];
    assign legal   = alu_ctl_legal(sel_ctl);

    alu #(.W(W)) u_alu (
        .ALUctl (sel_ctl),
        .A      (sel_a),
        .B      (sel_b),
        .ALUOut (alu_out),
        .Zero   (alu_zero)
    );

    always_comb begin
        valid_d  = valid_q;
        id_d     = id_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        ptr_d    = ptr_q;
        if (|gnt) begin
            valid_d  = 1'b1;
            id_d     = idx;
            result_d = legal ? alu_out : '0;
            zero_d   = legal && alu_zero;
            err_d    = !legal;
            ptr_d    = idx == IDW'(NREQ-1) ? '0 : idx + 1'b1;
        end else if (bus.out_ready) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            id_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            ptr_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            id_q     <= id_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.gnt        = gnt;
    assign bus.out_valid  = valid_q;
    assign bus.out_id     = id_q;
    assign bus.out_result = result_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_err    = err_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed vectors with a scoreboard queue drained by a result monitor.
module tb_alu_share_arb;
    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] res;
        logic        z;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    alu_share_arb_if #(.NREQ(4), .W(32), .IDW(2)) bus ();

    alu_share_arb #(.NREQ(4), .W(32), .IDW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.ctl[4*i +: 4]   = c;
        bus.a_in[32*i +: 32] = a;
        bus.b_in[32*i +: 32] = b;
    endtask

    task automatic push(input logic [1:0] id, input logic [31:0] r, input logic z, input logic e);
        sb.push_back({id, r, z, e});
    endtask

    // Monitor: every consumed result must match the oldest expectation.
    initial begin
        exp_t act, want;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                act = {bus.out_id, bus.out_result, bus.out_zero, bus.out_err};
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'(act), 64'hdead);
                end else begin
                    want = sb.pop_front();
                    chk("result", 64'(act), 64'(want));
                end
            end
        end
    end

    initial begin
        logic [31:0] fa [4];
        logic [31:0] fb [4];
        logic [31:0] fr [4];
        logic        fz [4];
        fa = '{32'hF0F0_F0F0, 32'h1234, 32'hFFFF_FFFF, 32'hAAAA_AAAA};
        fb = '{32'hFF00_FF00, 32'h0,    32'h8000_0001, 32'h5555_5555};
        fr = '{32'hF000_F000, 32'h0,    32'h8000_0001, 32'h0};
        fz = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst_n = 1'b0;
        bus.req = 4'b1111;
        bus.ctl = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.out_ready = 1'b1;
        step();
        chk("rst_gnt", 64'(bus.gnt), 0);
        chk("rst_valid", 64'(bus.out_valid), 0);
        chk("rst_outs", {bus.out_id, bus.out_result, bus.out_zero, bus.out_err}, 0);
        bus.req = '0;
        rst_n = 1'b1;
        step();
        bus.req = 4'b0001;
        op(0, 4'd2, 60, 60);
        push(0, 120, 0, 0);
        @(negedge clk) chk("add_gnt", 64'(bus.gnt), 4'b0001);
        step();
        bus.req = 4'b0100;
        op(2, 4'd6, 60, 60);
        push(2, 0, 1, 0);
        @(negedge clk) chk("sub_gnt", 64'(bus.gnt), 4'b0100);
        chk("add_valid_id", {bus.out_valid, bus.out_id}, {1'b1, 2'd0});
        step();
        op(2, 4'd7, 1, 2);
        push(2, 1, 0, 0);
        @(negedge clk) chk("slt_gnt", 64'(bus.gnt), 4'b0100);
        step();
        bus.req = 4'b1000;
        op(3, 4'd2, 7, 8);
        push(3, 15, 0, 0);
        @(negedge clk) chk("add3_gnt", 64'(bus.gnt), 4'b1000);
        step();
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) op(i, 4'd0, fa[i], fb[i]);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) step();
            push(2'(i % 4), fr[i % 4], fz[i % 4], 0);
            @(negedge clk) chk($sformatf("fair_gnt%0d", i), 64'(bus.gnt), 64'(4'b0001 << (i % 4)));
        end
        step();
        bus.req = 4'b0110;
        bus.out_ready = 1'b0;
        op(1, 4'd2, 100, 23);
        op(2, 4'd6, 5, 10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_gnt", 64'(bus.gnt), 0);
            chk("bp_hold", {bus.out_valid, bus.out_id, bus.out_result, bus.out_zero, bus.out_err},
                {1'b1, 2'd0, 32'hF000_F000, 1'b0, 1'b0});
            step();
        end
        bus.out_ready = 1'b1;
        push(1, 123, 0, 0);
        @(negedge clk) chk("drain_gnt", 64'(bus.gnt), 4'b0010);
        step();
        bus.req = 4'b0100;
        push(2, 32'hFFFF_FFFB, 0, 0);
        @(negedge clk) chk("bp_next_gnt", 64'(bus.gnt), 4'b0100);
        chk("drain_valid_id", {bus.out_valid, bus.out_id}, {1'b1, 2'd1});
        step();
        bus.req = 4'b0010;
        op(1, 4'd3, 5, 5);
        push(1, 0, 0, 1);
        @(negedge clk) chk("ill_gnt", 64'(bus.gnt), 4'b0010);
        step();
        bus.req = 4'b1100;
        op(2, 4'd1, 32'h0F, 32'hF0);
        op(3, 4'd12, 0, 0);
        push(2, 32'hFF, 0, 0);
        @(negedge clk) chk("ptr_adv_gnt", 64'(bus.gnt), 4'b0100);
        chk("ill_outs", {bus.out_id, bus.out_result, bus.out_zero, bus.out_err}, {2'd1, 32'd0, 1'b0, 1'b1});
        step();
        bus.req = 4'b1000;
        push(3, 32'hFFFF_FFFF, 0, 0);
        @(negedge clk) chk("nor_gnt", 64'(bus.gnt), 4'b1000);
        step();
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) op(i, 4'd2, 32'(3 + i), 4);
        push(0, 7, 0, 0);
        @(negedge clk) chk("pre_rst_gnt", 64'(bus.gnt), 4'b0001);
        step();
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.out_valid), 0);
        chk("async_rst_gnt", 64'(bus.gnt), 0);
        chk("async_rst_outs", {bus.out_id, bus.out_result, bus.out_zero, bus.out_err}, 0);
        sb.delete();
        step();
        chk("in_rst_gnt", 64'(bus.gnt), 0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        push(0, 7, 0, 0);
        @(negedge clk) chk("post_rst_gnt", 64'(bus.gnt), 4'b0001);
        step();
        bus.req = '0;
        step();
        step();
        chk("sb_empty", 64'(sb.size()), 0);
        chk("idle_valid", 64'(bus.out_valid), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and sequencer that shares one combinational `alu` instance among up to `NREQ` requesters, such as the decode, branch-compare and address-generation units. Each requester presents an ALUctl code and two 32-bit operands, holds them until granted, and receives a registered result tagged with its requester ID. A single-entry output register with valid/ready backpressure sits between the shared ALU and the consumer.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `W`, default 32: operand/result width; must match `alu`.
- `IDW`, default 2: width of requester ID, equal to clog2(NREQ).

Ports:
- `clk`  in  1  system clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request; held with operands until the matching `gnt` bit is seen.
- `ctl`  in  4*NREQ  ALUctl per requester; requester i uses bits [4i+3:4i].
- `a_in`  in  W*NREQ  operand A per requester, packed the same way.
- `b_in`  in  W*NREQ  operand B per requester, packed the same way.
- `gnt`  out  NREQ  one-hot, combinational; high in the cycle the request is accepted.
- `out_valid`  out  1  result register holds an unconsumed result.
- `out_ready`  in  1  consumer accepts the result this cycle.
- `out_id`  out  IDW  requester index that owns the result.
- `out_result`  out  W  ALUOut, registered.
- `out_zero`  out  1  Zero flag, registered.
- `out_err`  out  1  request carried an unsupported ALUctl.

## Operation
- Legal ALUctl codes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR. All other codes are illegal.
- Slot free condition: `free = !out_valid || out_ready`.
- Arbitration happens when `free` and `|req` are both true.
  - Search for the winner starts at `rr_ptr` and wraps modulo NREQ.
  - The first asserted `req` bit wins, and only that bit is driven on `gnt`.
  - No grant is issued when `free` is 0 or `rst_n` is 0.
- The winner's ctl, A and B are muxed into the shared `alu`.
- On the clock edge where `gnt` is nonzero:
  - `out_result` and `out_zero` load from the ALU output.
  - `out_id` loads the winner index, `out_err` loads 0, and `out_valid` is set to 1.
  - `rr_ptr` becomes (winner+1) mod NREQ.
- Illegal ALUctl: the request is still granted and consumes its slot. `out_result`=0, `out_zero`=0, `out_err`=1.
- Result consumed with no new grant (`out_valid && out_ready && gnt==0`): `out_valid` clears on the edge. The other output registers hold their values.
- Simultaneous drain and grant: the new result replaces the old one on the same edge and `out_valid` stays 1. This gives full throughput of 1 result per cycle.
- Backpressure (`out_valid && !out_ready`):
  - `gnt`=0.
  - All output registers hold stable.
  - `rr_ptr` holds.
- Requester contract: `req`/`ctl`/`a_in`/`b_in` stay stable from assertion through the `gnt` cycle. `req` may drop or re-assert in the cycle after `gnt`.
- Reset, asynchronous and allowed mid-operation:
  - `out_valid`=0, `out_id`=0, `out_result`=0, `out_zero`=0, `out_err`=0, `rr_ptr`=0.
  - `gnt` is forced to 0 while `rst_n`=0.
  - Any in-flight result is discarded; requesters must re-request after reset.

## Timing
- Request-to-grant latency is 0 cycles: `gnt` is combinational from `req`, `rr_ptr`, `out_valid` and `out_ready`.
- Grant-to-result latency is 1 cycle: `out_valid` and the result are visible after the grant edge.
- Critical path: priority pick, then operand mux, then `alu`, then the output register. No path from `out_ready` to the operands.
- Under full contention with `out_ready`=1, each requester is served once every NREQ cycles. A requester waits at most NREQ-1 cycles while the consumer is ready.

## Structure
- Shared package `alu_pkg` holds:
  - localparams `ALU_AND`=0, `ALU_OR`=1, `ALU_ADD`=2, `ALU_SUB`=6, `ALU_SLT`=7, `ALU_NOR`=12.
  - function `alu_ctl_legal(ctl)`.
- Sub-module `rr_pick` takes `req`, `ptr` and `en`, and returns `gnt` (one-hot) plus `idx`. It is parameterised by NREQ and reused by future arbiters.
- The existing `alu` is instantiated once, with ports ALUctl, A, B, ALUOut, Zero. It is not modified.

## Test plan
- Single ADD: req=0001, ctl0=2, A=60, B=60, out_ready=1 -> gnt=0001 in the same cycle; next cycle out_valid=1, out_id=0, out_result=120, out_zero=0.
- SUB zero flag: requester 2, ctl=6, A=60, B=60 -> out_result=0, out_zero=1, out_id=2. Then SLT with A=1, B=2 -> out_result=1.
- Fairness: req=1111 held, out_ready=1, ctl all 0 -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, and out_id sequence 0,1,2,3.
- Backpressure: out_valid=1 with out_ready=0 for 3 cycles while req=0110 -> gnt=0 and outputs stable. When out_ready=1, drain and grant occur on the same edge: gnt to index 1 (rr_ptr=1), and out_valid stays 1.
- Illegal op: ctl1=3, A=5, B=5 -> granted; out_err=1, out_result=0, out_zero=0. rr_ptr advances to 2.
- Reset mid-operation: rst_n low while out_valid=1 and req=1111 -> out_valid, gnt and out_* drop immediately. After release, the first grant goes to index 0.
